// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan serializer slice.
// Contents:
//   state_t  - IDLE/SHIFT state encoding of the serializer FSM
//   SEL_W    - width of the 16:1 mux select
//   DATA_W   - width of the word being serialized
//   stepSel  - next select index in the chosen scan direction (mod 16)
package mux_scan_pkg;

    localparam int SEL_W  = 4;
    localparam int DATA_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Moves the select one position in the scan direction, wrapping modulo 16.
    function automatic logic [SEL_W-1:0] stepSel(input logic [SEL_W-1:0] cur,
                                                 input bit               lsbFirst);
        return lsbFirst ? cur + SEL_W'(1) : cur - SEL_W'(1);
    endfunction

endpackage

// File: rtl/mux16to1.sv
// Plain 16:1 multiplexer that the serializer scans through.
// Ports:
//   in  [15:0] - data inputs, one per select index
//   sel [3:0]  - select index
//   out        - in[sel]
module mux16to1
    import mux_scan_pkg::*;
(
    input  logic [DATA_W-1:0] in,
    input  logic [SEL_W-1:0]  sel,
    output logic              out
);

    assign out = in[sel];

endmodule

// File: rtl/mux_scan_serializer.sv
// Parallel-in / serial-out stage: accepts a 16-bit word over a valid/ready
// handshake and walks the select of a 16:1 mux across every index, emitting
// one bit per accepted beat.
// Parameters:
//   LSB_FIRST  - 1: select counts 0..15, 0: select counts 15..0
// Ports:
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   load_valid / load_ready / load_data - word input handshake
//   ser_out / ser_valid / ser_ready / ser_last - serial output handshake
//   sel        - current mux select index
//   busy       - a word is in flight
module mux_scan_serializer
    import mux_scan_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last,
    output logic [SEL_W-1:0]  sel,
    output logic              busy
);

    localparam logic [SEL_W-1:0] SEL_START = LSB_FIRST ? '0 : '1;
    localparam logic [SEL_W-1:0] SEL_END   = LSB_FIRST ? '1 : '0;

    state_t              r_state;
    state_t              w_nextState;
    logic [DATA_W-1:0]   r_hold;
    logic [SEL_W-1:0]    r_sel;
    logic                w_loadAccept;
    logic                w_beatAdvance;

    // The serial bit comes straight from the registered word and select.
    mux16to1 u_mux (
        .in  (r_hold),
        .sel (r_sel),
        .out (ser_out)
    );

    assign sel = r_sel;

    // Next-state and handshake decode. load_ready opens during SHIFT only on
    // the accepted last beat, so a waiting word follows with no bubble.
    always_comb begin
        w_nextState = r_state;
        load_ready  = 1'b0;
        ser_valid   = 1'b0;
        ser_last    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                busy      = 1'b1;
                ser_last  = (r_sel == SEL_END);
                if (ser_last && ser_ready) begin
                    load_ready = 1'b1;
                    if (!load_valid) begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign w_loadAccept  = load_valid && load_ready;
    assign w_beatAdvance = (r_state == SHIFT) && ser_ready && !ser_last;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Hold register only changes on an accepted load; after the final beat
    // it keeps the old word so ser_out stays quiet and predictable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (w_loadAccept) begin
            r_hold <= load_data;
        end
    end

    // Select counter: restarts on every load, steps on each accepted non-last
    // beat, and otherwise parks (including at END after the word completes).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '0;
        end else if (w_loadAccept) begin
            r_sel <= SEL_START;
        end else if (w_beatAdvance) begin
            r_sel <= stepSel(r_sel, LSB_FIRST);
        end
    end

endmodule
